icache_refill: RTL



---
 rtl/icache_refill_pkg.sv | 28 ++
 rtl/icache_line_assembler.sv | 45 ++++
 rtl/icache_refill.sv | 127 ++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the I-cache line-fill engine.
// Default geometry: 128-bit line, 32-bit beats, 16 sets, 2 ways.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int BEATS = 4;
    localparam int OFF   = 4;

    function automatic int beats_of(input int line_bits, input int beat_bits);
        return line_bits / beat_bits;
    endfunction

    function automatic int off_of(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    // Clears the byte-offset bits so the memory side always sees a line-aligned read.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int off);
        return (addr >> off) << off;
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Collects memory return beats into a full cache line and flags rlast mismatches.
// Beat 0 lands in the lowest word of the line.
module icache_line_assembler #(
    parameter int data_width = 128,
    parameter int beat_width = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [beat_width-1:0] beat_data,
    input  logic                  beat_last,
    output logic [data_width-1:0] line,
    output logic                  full,
    output logic                  err
);

    localparam int beats = data_width / beat_width;
    localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(beats - 1);

    logic [cnt_w-1:0] cnt;
    logic             on_last;

    assign on_last = (cnt == last_idx);
    assign full    = beat_valid && on_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            line <= '0;
            err  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (beat_valid) begin
            line[cnt*beat_width +: beat_width] <= beat_data;
            cnt <= on_last ? '0 : cnt_w'(cnt + 1'b1);
            // rlast must appear on the final beat and nowhere else; the beat is kept regardless.
            if (beat_last != on_last)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill.sv
// I-cache line-fill engine: one miss -> one line read -> one data-array write.
// Optional macro ICACHE_REFILL_BYPASS_EN adds a fetch bypass of the assembled line.
//
// state | meaning
// IDLE  | ready for a miss; latch address, index and victim way on miss_valid
// REQ   | line read request held until mem_req_ready
// RECV  | accept return beats into the line buffer
// WRITE | single-cycle data-array write and refill_done pulse
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int addr_width  = 4,
    parameter int data_width  = 128,
    parameter int beat_width  = 32,
    parameter int way         = 2,
    parameter int paddr_width = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [paddr_width-1:0] miss_paddr,
    input  logic [way-1:0]         miss_way,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [paddr_width-1:0] mem_req_addr,
    input  logic                   mem_rvalid,
    output logic                   mem_rready,
    input  logic [beat_width-1:0]  mem_rdata,
    input  logic                   mem_rlast,
    output logic [data_width-1:0]  Data_din_write,
    output logic [addr_width-1:0]  Data_addr_write,
    output logic [way-1:0]         Data_we,
    output logic                   refill_done,
`ifdef ICACHE_REFILL_BYPASS_EN
    output logic                   bypass_valid,
    output logic [data_width-1:0]  bypass_line,
`endif
    output logic                   refill_err
);

    localparam int off = off_of(data_width);

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   line_full;
    logic [data_width-1:0]  line;
    logic [paddr_width-1:0] line_addr_q;
    logic [addr_width-1:0]  index_q;
    logic [way-1:0]         way_q;

    assign accept = miss_ready && miss_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_valid)    state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RECV;
            RECV:    if (line_full)     state_nxt = WRITE;
            WRITE:                      state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_rready    = 1'b0;
        Data_we       = '0;
        refill_done   = 1'b0;
        case (state)
            IDLE:  miss_ready    = 1'b1;
            REQ:   mem_req_valid = 1'b1;
            RECV:  mem_rready    = 1'b1;
            WRITE: begin
                Data_we     = way_q;
                refill_done = 1'b1;
            end
            default: miss_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_addr_q <= '0;
            index_q     <= '0;
            way_q       <= '0;
        end else if (accept) begin
            line_addr_q <= paddr_width'(line_align(64'(miss_paddr), off));
            index_q     <= miss_paddr[off+addr_width-1:off];
            way_q       <= miss_way;
        end
    end

    icache_line_assembler #(
        .data_width (data_width),
        .beat_width (beat_width)
    ) u_assembler (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (accept),
        .beat_valid (mem_rvalid && mem_rready),
        .beat_data  (mem_rdata),
        .beat_last  (mem_rlast),
        .line       (line),
        .full       (line_full),
        .err        (refill_err)
    );

    assign mem_req_addr    = line_addr_q;
    assign Data_addr_write = index_q;
    assign Data_din_write  = line;

`ifdef ICACHE_REFILL_BYPASS_EN
    assign bypass_valid = (state == WRITE);
    assign bypass_line  = line;
`endif

endmodule
